// File: rtl/button_event_fifo_if.sv
// Consumer-side event handshake of the button event FIFO.
// The FIFO is the master. It drives the head code and the valid flag.
// The consumer (slave) answers with ready.
interface button_event_fifo_if #(
  parameter int CODE_W = 3
) ();
  logic [CODE_W-1:0] evt_code;
  logic              evt_valid;
  logic              evt_ready;

  modport master (
    output evt_code,
    output evt_valid,
    input  evt_ready
  );

  modport slave (
    input  evt_code,
    input  evt_valid,
    output evt_ready
  );
endinterface

// File: rtl/button_event_fifo.sv
// Button event FIFO.
// Each debounced button flag is synchronised into the clk domain and edge
// detected. Every rising edge becomes a pending request. Pending requests
// drain into a small show-ahead FIFO, lowest button index first and one per
// cycle. The consumer pops entries with a valid/ready handshake. A press that
// arrives while the same button still has an undelivered pending press is
// dropped and recorded in a sticky overflow flag.
module button_event_fifo #(
  parameter int NBTN   = 5,
  parameter int DEPTH  = 4,
  parameter int CODE_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NBTN-1:0]          btn_in,
  button_event_fifo_if.master      evt,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NBTN-1:0]   s1, s2, s3;
  logic [NBTN-1:0]   rise;
  logic [NBTN-1:0]   pend;
  logic [NBTN-1:0]   sel_mask;
  logic [CODE_W-1:0] sel;
  logic [CODE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;
  logic              valid;
  logic              full;
  logic              push;
  logic              pop;
  logic              ov_set;

  // Two-flop synchroniser followed by the edge-history flop. All three reset to 0
  // so that a button held through reset release still produces one event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Priority pick of the lowest pending button index.
  always_comb begin
    sel = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (pend[i]) sel = CODE_W'(i);
    end
  end

  assign valid    = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop      = valid && evt.evt_ready;
  assign push     = (pend != '0) && (!full || pop);
  assign sel_mask = push ? (NBTN'(1) << sel) : '0;
  assign ov_set   = |(rise & pend & ~sel_mask);

  // Pending mask: the pushed request leaves, and new rises join. A rise on a bit
  // that is still pending leaves it set, which keeps the older press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= (pend & ~sel_mask) | rise;
  end

  // Storage array. It has no reset because its contents are only visible through the valid-masked head.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= sel;
  end

  // Read/write pointers and occupancy count. The pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow. A dropped press in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              overflow <= 1'b0;
    else if (ov_set)       overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

  assign evt.evt_valid = valid;
  assign evt.evt_code  = valid ? mem[rptr] : '0;
  assign evt_count     = count;

endmodule

// File: tb/tb_button_event_fifo.sv
// Scoreboard testbench for button_event_fifo.
// A queue-based reference model predicts the event stream from the button levels.
// A separate monitor compares every handshake pop with the scoreboard.
`timescale 1ns/1ps
module tb_button_event_fifo;

  localparam int NBTN  = 5;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] btn = '0;
  logic       ovclr = 1'b0;
  logic [2:0] evt_count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  button_event_fifo_if #(.CODE_W(3)) bus ();

  button_event_fifo #(.NBTN(NBTN), .DEPTH(DEPTH), .CODE_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn),
    .evt          (bus),
    .evt_count    (evt_count),
    .overflow     (overflow),
    .overflow_clr (ovclr)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Model state. The queue holds the codes currently stored in the FIFO.
  // The sample array holds the button levels seen on the last three edges.
  int         m_q [$];
  int         exp_q [$];
  logic [4:0] m_pend = '0;
  logic       m_ov = 1'b0;
  logic [4:0] smp [3];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] b, input logic r, input logic c, input int n);
    btn = b;
    bus.evt_ready = r;
    ovclr = c;
    repeat (n) @(negedge clk);
  endtask

  // Reference model.
  // A press is seen two edges after its level is sampled. It then waits in a pending set.
  // Each edge, the lowest pending button moves into the queue if the queue has room.
  always @(posedge clk or negedge rst) begin
    logic [4:0] rise;
    logic       do_pop, do_push, ov_hit, found;
    int         pick;
    if (!rst) begin
      for (int k = 0; k < 3; k++) smp[k] = '0;
      m_pend = '0;
      m_ov   = 1'b0;
      m_q.delete();
      exp_q.delete();
    end else begin
      rise    = smp[1] & ~smp[2];
      do_pop  = (m_q.size() != 0) && bus.evt_ready;
      found   = 1'b0;
      pick    = 0;
      for (int i = 0; i < NBTN; i++) begin
        if (!found && m_pend[i]) begin
          found = 1'b1;
          pick  = i;
        end
      end
      do_push = found && (m_q.size() < DEPTH || do_pop);
      ov_hit  = 1'b0;
      for (int i = 0; i < NBTN; i++) begin
        if (rise[i] && m_pend[i] && !(do_push && pick == i)) ov_hit = 1'b1;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(pick);
        exp_q.push_back(pick);
        m_pend[pick] = 1'b0;
      end
      m_pend = m_pend | rise;
      if (ov_hit)     m_ov = 1'b1;
      else if (ovclr) m_ov = 1'b0;
      smp[2] = smp[1];
      smp[1] = smp[0];
      smp[0] = btn;
    end
  end

  // Monitor: every accepted handshake must deliver the oldest code the scoreboard expects.
  always @(posedge clk) begin
    int e;
    if (rst && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("pop_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pop_code", int'(bus.evt_code), e);
      end
    end
  end

  // Per-cycle comparison of the visible status against the model, shortly after each edge.
  always @(posedge clk) begin
    #1;
    checkOutput("valid", int'(bus.evt_valid), int'(m_q.size() != 0));
    checkOutput("code", int'(bus.evt_code), (m_q.size() != 0) ? m_q[0] : 0);
    checkOutput("count", int'(evt_count), m_q.size());
    checkOutput("overflow", int'(overflow), int'(m_ov));
  end

  // Stops the run if it ever stalls.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus sequence.
  initial begin
    int seq3 [5];
    int seq4 [6];
    int budget;
    seq3 = '{3, 1, 0, 2, 4};
    seq4 = '{0, 1, 2, 3, 4, 4};
    bus.evt_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_count", int'(evt_count), 0);
    checkOutput("reset_valid", int'(bus.evt_valid), 0);
    rst = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, 2);

    // Single press: the event appears after the fourth edge.
    btn = 5'b00100;
    repeat (3) @(posedge clk);
    #2 checkOutput("t1_not_yet", int'(bus.evt_valid), 0);
    @(posedge clk);
    #2 checkOutput("t1_latency", int'(bus.evt_valid), 1);
    checkOutput("t1_code", int'(bus.evt_code), 2);
    @(negedge clk);
    applyStimulus(5'b00100, 1'b0, 1'b0, 6);
    applyStimulus('0, 1'b0, 1'b0, 4);
    checkOutput("t1_count", int'(evt_count), 1);
    applyStimulus('0, 1'b1, 1'b0, 4);

    // Simultaneous rises drain lowest index first.
    applyStimulus(5'b10011, 1'b1, 1'b0, 3);
    applyStimulus('0, 1'b1, 1'b0, 8);
    checkOutput("t2_overflow", int'(overflow), 0);
    checkOutput("t2_empty", int'(evt_count), 0);

    // Five presses against a stalled consumer. The fifth press waits in pend.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'(1 << seq3[i]), 1'b0, 1'b0, 2);
      applyStimulus('0, 1'b0, 1'b0, 4);
    end
    checkOutput("t3_full", int'(evt_count), 4);
    applyStimulus('0, 1'b1, 1'b0, 10);
    checkOutput("t3_drained", int'(evt_count), 0);

    // A repeated press while full and pending sets overflow. A clear then drops it.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(5'(1 << seq4[i]), 1'b0, 1'b0, 2);
      applyStimulus('0, 1'b0, 1'b0, 4);
    end
    checkOutput("t4_overflow_set", int'(overflow), 1);
    checkOutput("t4_full", int'(evt_count), 4);
    applyStimulus('0, 1'b0, 1'b1, 1);
    applyStimulus('0, 1'b0, 1'b0, 1);
    checkOutput("t4_overflow_clr", int'(overflow), 0);

    // Pop and push in the same cycle while full.
    applyStimulus('0, 1'b1, 1'b0, 1);
    checkOutput("t5_count_held", int'(evt_count), 4);
    applyStimulus('0, 1'b0, 1'b0, 2);
    applyStimulus('0, 1'b1, 1'b0, 8);

    // Reset with queued and pending presses, with button 0 held through release.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'(1 << i), 1'b0, 1'b0, 2);
      applyStimulus('0, 1'b0, 1'b0, 4);
    end
    applyStimulus(5'b01000, 1'b0, 1'b0, 3);
    rst = 1'b0;
    btn = 5'b00001;
    #1;
    checkOutput("t6_rst_count", int'(evt_count), 0);
    checkOutput("t6_rst_valid", int'(bus.evt_valid), 0);
    checkOutput("t6_rst_code", int'(bus.evt_code), 0);
    @(negedge clk);
    applyStimulus(5'b00001, 1'b0, 1'b0, 3);
    rst = 1'b1;
    applyStimulus(5'b00001, 1'b0, 1'b0, 10);
    checkOutput("t6_one_event", int'(evt_count), 1);
    checkOutput("t6_code", int'(bus.evt_code), 0);
    applyStimulus('0, 1'b1, 1'b0, 4);

    // Random traffic: sparse button toggles, a varying consumer and occasional clears.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] b;
      b = btn;
      if ($urandom_range(0, 3) == 0) b[$urandom_range(0, NBTN - 1)] ^= 1'b1;
      applyStimulus(b, (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 15) == 0), 1);
    end

    // Drain everything with a bounded wait.
    btn = '0;
    bus.evt_ready = 1'b1;
    ovclr = 1'b0;
    budget = 0;
    while ((exp_q.size() != 0 || m_q.size() != 0 || m_pend != '0) && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    applyStimulus('0, 1'b1, 1'b0, 6);
    checkOutput("drain_scoreboard", exp_q.size(), 0);
    checkOutput("drain_count", int'(evt_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
